cpu_mem_bus_arbiter: RTL
========================

// Module: cpu_mem_bus_arbiter
// PURPOSE
//  Registered N-port arbiter between the L1 caches and the single memory bus. Replaces the
//  fixed 2-way dcache/icache combinational router. Adds: configurable port count, fixed or
//  round-robin priority, a request-ready handshake and per-port pending-read tracking.
//  Routes id-tagged responses back to the issuing port.
// PARAMETERS
//  NUM_PORTS   2    requesting masters; port 0 = dcache, port 1 = icache.
//  ADDR_WIDTH  32   memory address width.
//  DATA_WIDTH  128  cache line width.
//  ARB_MODE    0    0 = fixed priority (lowest index wins); 1 = round-robin.
//  STARVE_LIM  16   wait-cycle limit for the starvation guard (see CONFIGURATION).
//  ID_WIDTH    localparam = max(1, $clog2(NUM_PORTS)).
// PORTS
//  clock           in   1                    single clock.
//  reset           in   1                    synchronous, active-low.
//  req_read        in   NUM_PORTS            per-port read request.
//  req_write       in   NUM_PORTS            per-port write request; read and write are mutually exclusive per port.
//  req_addr        in   NUM_PORTS*ADDR_WIDTH packed, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
//  req_data        in   NUM_PORTS*DATA_WIDTH packed write data.
//  req_ready       out  NUM_PORTS            one-hot pulse; request captured this cycle.
//  resp_valid      out  NUM_PORTS            one-hot response strobe.
//  resp_addr       out  ADDR_WIDTH           response address, shared by all ports.
//  resp_data       out  DATA_WIDTH           response data, shared by all ports.
//  resp_err        out  1                    sticky: a response arrived with no matching pending read.
//  mem_req_valid   out  1                    memory request valid.
//  mem_req_read    out  1                    read command.
//  mem_req_write   out  1                    write command.
//  mem_req_id      out  ID_WIDTH             id of the issuing port.
//  mem_req_addr    out  ADDR_WIDTH           request address.
//  mem_req_data    out  DATA_WIDTH           request write data.
//  mem_req_ready   in   1                    memory accepts the request.
//  mem_resp_valid  in   1                    memory response valid.
//  mem_resp_id     in   ID_WIDTH             response id.
//  mem_resp_addr   in   ADDR_WIDTH           response address.
//  mem_resp_data   in   DATA_WIDTH           response data.
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; all outputs 0; pending=0; rr_ptr=0; wait counters=0.
//  Eligible[i] = (req_read[i] | req_write[i]) & ~pending[i].
//  FSM IDLE:
//    - If any port is eligible: pick a winner by ARB_MODE.
//    - req_ready[winner]=1, combinational, in this cycle.
//    - Capture the winner's cmd/id/addr/data into the output registers; go HOLD.
//    - The master must drop or advance its request the following cycle.
//  FSM HOLD:
//    - mem_req_valid=1; all mem_req_* fields held stable.
//    - On mem_req_ready: go IDLE. If the command was a read, set pending[id].
//    - Capture-to-valid latency is 1 cycle; throughput is 1 request per 2 cycles minimum.
//  Writes are posted: they never set pending and expect no response.
//  Round-robin: search starts at rr_ptr; on capture, rr_ptr <= (winner+1) mod NUM_PORTS.
//  Response path, registered, latency 1:
//    - mem_resp_valid with pending[id]: resp_valid[id]=1 next cycle, addr/data registered, pending[id] cleared.
//    - If pending[id]==0 or id >= NUM_PORTS: response dropped, resp_err<=1.
//    - A response may arrive in the same cycle as a HOLD handshake from another port.
//      Both take effect; a set and a clear for the same id cannot coincide.
//  Reset mid-transaction:
//    - Held request is abandoned; pending is cleared.
//    - Late responses are dropped and flag resp_err. This is a legal, expected flag after reset.
//  Request changing while not granted is legal. Only the captured copy matters.
// CONFIGURATION
//  CPU_ARB_STARVE_GUARD_EN defined:
//    - Each port has a wait counter: increments while eligible and not granted, clears on grant.
//    - A port reaching STARVE_LIM wins next arbitration, overriding ARB_MODE.
//    - Ties between starved ports go to the lowest index.
//  Undefined: no counters; pure ARB_MODE policy, so port 1 may starve under fixed mode.
// STRUCTURE
//  Package cpu_mem_arb_pkg holds:
//    - arb_mode_e {ARB_FIXED, ARB_RR};
//    - arb_state_e {ARB_IDLE, ARB_HOLD};
//    - the id-width function.
//  Sub-module cpu_rr_picker: combinational masked priority picker (req vector, start pointer)
//  -> one-hot grant plus index. Fixed mode uses start=0.
// TESTING
//  - Reset: reset=0 for 2 cycles, then ports 0 and 1 read -> all outputs 0 during reset;
//    req_ready=2'b01 on the first cycle after.
//  - Fixed mode, both read, mem_req_ready=1:
//    - Port 0 granted; pending[0] blocks it, so port 1 is granted next.
//    - mem_req_id sequence is 0, 1.
//  - RR mode, ports 0 and 1 writing continuously with mem_req_ready=1 -> grants alternate 0,1,0,1.
//    Writes set no pending.
//  - Backpressure: mem_req_ready=0 for 5 cycles -> addr 0x100 held stable, no new req_ready;
//    exactly one handshake when ready rises.
//  - Response id=1 addr 0x40 data 0xDEAD with pending[1] -> resp_valid=2'b10 next cycle,
//    data 0xDEAD. Same response repeated -> dropped, resp_err=1.
//  - With CPU_ARB_STARVE_GUARD_EN, fixed mode, port 0 always requesting writes ->
//    port 1 granted once it has waited STARVE_LIM=16 cycles.

Source files
------------

// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and sizing helper for the cache-to-memory bus arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package cpu_mem_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // Port id width; a single-port build still needs a 1-bit id field.
    function automatic int arb_id_width(input int num_ports);
        int w;
        w = $clog2(num_ports);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cpu_rr_picker.sv
// Masked priority picker: first requester at or after start, wrapping round.
// Latency: combinational.
// Backpressure: none, pure function of req and start.
module cpu_rr_picker
    import cpu_mem_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int IDXW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // Two passes: indices from start upward first, then the wrapped low indices.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (IDXW'(i) >= start)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDXW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (IDXW'(i) < start)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_mem_bus_arbiter.sv
// N-port L1-to-memory arbiter with registered request stage, per-port read tracking and id-routed responses.
// Latency: capture to mem_req_valid 1 cycle; mem_resp to resp_valid 1 cycle; at most 1 request per 2 cycles.
// Backpressure: request held stable in HOLD until mem_req_ready; no new req_ready meanwhile. Optional starvation guard: CPU_ARB_STARVE_GUARD_EN.
module cpu_mem_bus_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int  NUM_PORTS  = 2,
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 128,
    parameter int  ARB_MODE   = 0,
    parameter int  STARVE_LIM = 16,
    localparam int ID_WIDTH   = arb_id_width(NUM_PORTS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [ADDR_WIDTH-1:0]           resp_addr,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic                            resp_err,
    output logic                            mem_req_valid,
    output logic                            mem_req_read,
    output logic                            mem_req_write,
    output logic [ID_WIDTH-1:0]             mem_req_id,
    output logic [ADDR_WIDTH-1:0]           mem_req_addr,
    output logic [DATA_WIDTH-1:0]           mem_req_data,
    input  logic                            mem_req_ready,
    input  logic                            mem_resp_valid,
    input  logic [ID_WIDTH-1:0]             mem_resp_id,
    input  logic [ADDR_WIDTH-1:0]           mem_resp_addr,
    input  logic [DATA_WIDTH-1:0]           mem_resp_data
);

    arb_state_e             state_q, state_d;
    logic                   mreq_read_q, mreq_read_d;
    logic                   mreq_write_q, mreq_write_d;
    logic [ID_WIDTH-1:0]    mreq_id_q, mreq_id_d;
    logic [ADDR_WIDTH-1:0]  mreq_addr_q, mreq_addr_d;
    logic [DATA_WIDTH-1:0]  mreq_data_q, mreq_data_d;
    logic [NUM_PORTS-1:0]   pending_q, pending_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]   resp_valid_q, resp_valid_d;
    logic [ADDR_WIDTH-1:0]  resp_addr_q, resp_addr_d;
    logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
    logic                   resp_err_q, resp_err_d;

    logic [NUM_PORTS-1:0]   eligible;
    logic [NUM_PORTS-1:0]   starved;
    logic [NUM_PORTS-1:0]   arb_gnt, st_gnt, win_gnt;
    logic [ID_WIDTH-1:0]    arb_idx, st_idx, win_idx;
    logic [ID_WIDTH-1:0]    rr_start;
    logic                   arb_any, st_any;
    logic                   hold_done;
    logic [NUM_PORTS-1:0]   resp_id_dec;
    logic [NUM_PORTS-1:0]   resp_hit;

    // A port with a read in flight may not issue again until its response returns.
    assign eligible = (req_read | req_write) & ~pending_q;
    assign rr_start = (ARB_MODE == int'(ARB_RR)) ? rr_ptr_q : '0;

    cpu_rr_picker #(.N(NUM_PORTS), .IDXW(ID_WIDTH)) u_arb_pick (
        .req   (eligible),
        .start (rr_start),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Starved ports are a subset of eligible ones; lowest index wins among them.
    cpu_rr_picker #(.N(NUM_PORTS), .IDXW(ID_WIDTH)) u_starve_pick (
        .req   (starved),
        .start ('0),
        .gnt   (st_gnt),
        .idx   (st_idx),
        .any   (st_any)
    );

    assign win_gnt = st_any ? st_gnt : arb_gnt;
    assign win_idx = st_any ? st_idx : arb_idx;

`ifdef CPU_ARB_STARVE_GUARD_EN
    localparam int WCNT_W = $clog2(STARVE_LIM + 1);
    logic [NUM_PORTS-1:0][WCNT_W-1:0] wait_q, wait_d;

    // A port whose wait count reached the limit overrides the normal policy.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            starved[i] = eligible[i] && (wait_q[i] >= WCNT_W'(STARVE_LIM));
        end
    end

    // Age eligible ports that were not granted; saturate at the limit, clear on grant.
    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_ready[i]) begin
                wait_d[i] = '0;
            end else if (eligible[i] && (wait_q[i] < WCNT_W'(STARVE_LIM))) begin
                wait_d[i] = wait_q[i] + WCNT_W'(1);
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign starved = '0;
`endif

    // IDLE arbitrates and captures the winner; HOLD presents it until memory accepts.
    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        rr_ptr_d     = rr_ptr_q;
        mreq_read_d  = mreq_read_q;
        mreq_write_d = mreq_write_q;
        mreq_id_d    = mreq_id_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_data_d  = mreq_data_q;
        hold_done    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (reset && arb_any) begin
                    req_ready    = win_gnt;
                    mreq_read_d  = req_read[win_idx];
                    mreq_write_d = req_write[win_idx];
                    mreq_id_d    = win_idx;
                    mreq_addr_d  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    mreq_data_d  = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    rr_ptr_d     = (win_idx == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
                    state_d      = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (mem_req_ready) begin
                    hold_done = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Decode the response id; out-of-range ids decode to nothing and so count as unmatched.
    always_comb begin
        resp_id_dec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            resp_id_dec[i] = (mem_resp_id == ID_WIDTH'(i));
        end
    end

    assign resp_hit = pending_q & resp_id_dec;

    // Track outstanding reads and route or drop responses; set and clear never share an id.
    always_comb begin
        pending_d    = pending_q;
        resp_valid_d = '0;
        resp_addr_d  = resp_addr_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if (hold_done && mreq_read_q) begin
            pending_d[mreq_id_q] = 1'b1;
        end
        if (mem_resp_valid) begin
            if (|resp_hit) begin
                resp_valid_d = resp_hit;
                resp_addr_d  = mem_resp_addr;
                resp_data_d  = mem_resp_data;
                pending_d    = pending_d & ~resp_hit;
            end else begin
                resp_err_d = 1'b1;
            end
        end
    end

    // State, request and response registers; reset abandons any held request and in-flight reads.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            mreq_read_q  <= 1'b0;
            mreq_write_q <= 1'b0;
            mreq_id_q    <= '0;
            mreq_addr_q  <= '0;
            mreq_data_q  <= '0;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            resp_valid_q <= '0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mreq_read_q  <= mreq_read_d;
            mreq_write_q <= mreq_write_d;
            mreq_id_q    <= mreq_id_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_data_q  <= mreq_data_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign mem_req_valid = (state_q == ARB_HOLD);
    assign mem_req_read  = mreq_read_q;
    assign mem_req_write = mreq_write_q;
    assign mem_req_id    = mreq_id_q;
    assign mem_req_addr  = mreq_addr_q;
    assign mem_req_data  = mreq_data_q;
    assign resp_valid    = resp_valid_q;
    assign resp_addr     = resp_addr_q;
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;

endmodule
